// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit with a valid/ready port to variable-latency dmem.
// Optional macro LSU_TIMEOUT_EN adds a WAIT-state timeout that traps the access.
module lsu_mem_port #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [31:0]         i_req_addr,
    input  logic [DATA_W-1:0]   i_req_wdata,
    input  logic                i_req_wen,
    input  logic [2:0]          i_req_funct3,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic [31:0]         o_mem_addr,
    output logic                o_mem_ren,
    output logic                o_mem_wen,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_mask,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_rsp_valid,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_trap,
    output logic                o_busy
);

    localparam int MASK_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(MASK_W);

    if ((DATA_W != 32 && DATA_W != 64) ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("lsu_mem_port: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_mem_valid;
    logic                r_mem_ren;
    logic                r_mem_wen;
    logic [31:0]         r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [MASK_W-1:0]   r_mem_mask;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_trap;
    logic                r_busy;
    logic                r_is_store;
    logic [OFF_W-1:0]    r_off;
    logic [2:0]          r_funct3;
`ifdef LSU_TIMEOUT_EN
    logic [15:0]         r_tmo_cnt;
    logic                w_tmo_hit;
`endif

    logic [OFF_W-1:0]    w_off;
    logic [OFF_W-1:0]    w_align;
    logic [MASK_W-1:0]   w_mask;
    logic                w_illegal;
    logic                w_misal;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_shift;
    logic [DATA_W-1:0]   w_keep;
    logic                w_sign;
    logic [DATA_W-1:0]   w_ldata;

    assign w_off   = i_req_addr[OFF_W-1:0];
    assign w_misal = |(w_off & w_align);
    assign w_wdata = i_req_wdata << {w_off, 3'b000};

    // Request decode: lane mask, alignment requirement and size legality.
    always_comb begin
        w_mask    = '0;
        w_align   = '0;
        w_illegal = 1'b0;
        unique case (i_req_funct3[1:0])
            2'b00: begin
                w_mask  = MASK_W'(1) << w_off;
            end
            2'b01: begin
                w_mask  = MASK_W'(3) << w_off;
                w_align = OFF_W'(1);
            end
            2'b10: begin
                w_mask  = MASK_W'(15) << w_off;
                w_align = OFF_W'(3);
            end
            default: begin
                w_mask    = '1;
                w_align   = '1;
                w_illegal = (DATA_W == 32);
            end
        endcase
    end

    assign w_shift = i_mem_rdata >> {r_off, 3'b000};

    // Load return path: keep the accessed bytes, fill the rest with sign or zero.
    always_comb begin
        w_keep = '1;
        w_sign = 1'b0;
        unique case (r_funct3[1:0])
            2'b00: begin
                w_keep = DATA_W'(8'hFF);
                w_sign = w_shift[7];
            end
            2'b01: begin
                w_keep = DATA_W'(16'hFFFF);
                w_sign = w_shift[15];
            end
            2'b10: begin
                w_keep = DATA_W'(32'hFFFF_FFFF);
                w_sign = w_shift[31];
            end
            default: begin
                w_keep = '1;
                w_sign = 1'b0;
            end
        endcase
    end

    assign w_ldata = (w_shift & w_keep) |
                     ((w_sign && !r_funct3[2]) ? ~w_keep : '0);

`ifdef LSU_TIMEOUT_EN
    assign w_tmo_hit = (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`endif

    // Transaction FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_mem_valid <= 1'b0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_mask  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_trap  <= 1'b0;
            r_busy      <= 1'b0;
            r_is_store  <= 1'b0;
            r_off       <= '0;
            r_funct3    <= '0;
`ifdef LSU_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_req_valid && r_req_ready) begin
                        r_mem_addr  <= {i_req_addr[31:OFF_W], {OFF_W{1'b0}}};
                        r_mem_mask  <= w_mask;
                        r_mem_wdata <= w_wdata;
                        r_off       <= w_off;
                        r_funct3    <= i_req_funct3;
                        r_is_store  <= i_req_wen;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_misal || w_illegal) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_trap  <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state     <= S_REQ;
                            r_mem_valid <= 1'b1;
                            r_mem_ren   <= !i_req_wen;
                            r_mem_wen   <= i_req_wen;
                        end
                    end
                end
                S_REQ: begin
                    if (i_mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_mem_ren   <= 1'b0;
                        r_mem_wen   <= 1'b0;
                        if (r_is_store) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_trap  <= 1'b0;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state <= S_WAIT;
`ifdef LSU_TIMEOUT_EN
                            r_tmo_cnt <= '0;
`endif
                        end
                    end
                end
                S_WAIT: begin
                    if (i_mem_rvalid) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_trap  <= 1'b0;
                        r_rsp_rdata <= w_ldata;
`ifdef LSU_TIMEOUT_EN
                    end else if (w_tmo_hit) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_trap  <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
`endif
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_trap  <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_mem_valid = r_mem_valid;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_ren   = r_mem_ren;
    assign o_mem_wen   = r_mem_wen;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_mask  = r_mem_mask;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_trap  = r_rsp_trap;
    assign o_busy      = r_busy;

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit placed between the hart execute stage and a realistic, variable-latency data memory. It replaces the combinational dmem port used so far.
- Accepts one load/store request per transaction and builds the word-aligned address, byte mask and lane-shifted write data.
- Drives a valid/ready memory request, waits for the read response, then returns sign/zero-extended load data or a trap to the pipeline.
- Parametrised in data width and timeout. Adds misalignment trapping and handshake stalls, which the combinational port cannot provide.

Parameters:
- DATA_W, 32, memory/register data width; legal values are 32 and 64. Mask width MASK_W = DATA_W/8.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before the access is aborted with a trap; legal range 1..65535.

Ports:
- i_clk  input  1  global clock
- i_rst_n  input  1  reset, synchronous, active-low
- i_req_valid  input  1  pipeline presents a memory op
- o_req_ready  output  1  LSU can accept a request (high only in IDLE)
- i_req_addr  input  32  byte address (rs1 + imm)
- i_req_wdata  input  DATA_W  store value, unshifted (rs2)
- i_req_wen  input  1  1 = store, 0 = load
- i_req_funct3  input  3  size[1:0] (00 b, 01 h, 10 w, 11 d) plus unsigned bit [2]
- o_mem_valid  output  1  memory request valid
- i_mem_ready  input  1  memory accepts the request
- o_mem_addr  output  32  address aligned to DATA_W/8 bytes
- o_mem_ren  output  1  read request
- o_mem_wen  output  1  write request
- o_mem_wdata  output  DATA_W  lane-shifted write data
- o_mem_mask  output  MASK_W  byte-lane enables
- i_mem_rvalid  input  1  read data valid
- i_mem_rdata  input  DATA_W  read data word
- o_rsp_valid  output  1  one-cycle completion pulse
- o_rsp_rdata  output  DATA_W  extended load result; 0 for stores and traps
- o_rsp_trap  output  1  misaligned, illegal-size or timeout
- o_busy  output  1  state != IDLE

Behaviour:
- Reset (i_rst_n low at posedge):
  - State goes to IDLE.
  - All outputs are 0 except o_req_ready, which is 1.
  - The timeout counter is cleared.
  - Reset mid-transaction abandons the access with no response.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Handshake is i_req_valid & o_req_ready.
  - All request fields are registered on the handshake.
  - If the request is misaligned, or is size 11 with DATA_W=32, go to RESP with trap=1 and issue no memory request.
  - Otherwise go to REQ.
  - Misaligned means the offset within the word is not a multiple of the access size.
- REQ:
  - o_mem_valid=1 and all request fields are held stable until i_mem_ready.
  - On handshake, a store goes to RESP and a load goes to WAIT.
- WAIT:
  - i_mem_rvalid is sampled here only; it is never sampled in the REQ handshake cycle.
  - On rvalid, latch the extended data and go to RESP.
- RESP: o_rsp_valid=1 for exactly one cycle, then return to IDLE. There is no response backpressure.
- Latency: handshake at cycle 0 → o_mem_valid at cycle 1. For zero-wait memory, a store responds at cycle 2; a load with rvalid at cycle k responds at k+1. Minimum load latency is 3.
- Mask generation: offset = addr[log2(MASK_W)-1:0]. Byte mask = 1<<offset; half = 2'b11<<offset; word = 4'hF<<offset; dword = all ones.
- Write data: i_req_wdata shifted left by 8*offset.
- Load data: i_mem_rdata shifted right by 8*offset, then sign- or zero-extended from the access size to DATA_W per funct3[2].
- o_mem_ren and o_mem_wen are mutually exclusive and asserted only while o_mem_valid is high.
- o_mem_addr clears the low log2(MASK_W) bits.
- Stray i_mem_rvalid outside WAIT is ignored.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A 16-bit counter increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES, go to RESP with trap=1 and rdata=0.
  - The counter clears on WAIT entry.
  - If rvalid arrives on the same cycle as the limit, the data wins and trap=0.
- Undefined: no counter; WAIT waits indefinitely and the TIMEOUT_CYCLES parameter is ignored.

Test Plan:
- Load-byte sign extension: DATA_W=32, lb addr 0x1003, memory ready immediately, rdata 0x80xx_xxxx after 2 cycles → o_mem_addr=0x1000, mask=4'b1000; o_rsp_rdata=0xFFFFFF80, trap=0 at cycle 5.
- Store-half upper lanes: sh addr 0x2002, wdata 0x0000BEEF, i_mem_ready held low 3 cycles → o_mem_valid and fields stable throughout; mask=4'b1100, wdata=0xBEEF0000; o_rsp_valid 1 cycle after ready.
- Misaligned load: lw addr 0x3001 → o_mem_valid never asserted; o_rsp_valid with trap=1 at cycle 1.
- Illegal doubleword: DATA_W=32, funct3=011 → trap=1 with no memory access.
- Doubleword load: DATA_W=64, ld addr 0x4008 → mask=8'hFF, o_rsp_rdata equals i_mem_rdata.
- Timeout and reset: with LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, a load with no rvalid gives trap=1 after 4 WAIT cycles. Reset asserted in WAIT gives IDLE next cycle, o_rsp_valid=0, o_req_ready=1.
